target_burst_port: RTL and testbench
====================================

TARGET_BURST_PORT -- requirements
Module: target_burst_port

Interface
REQ-001 Parameter ADDR_WIDTH, 16, width of the target address and of the serial address field.
REQ-002 Parameter DATA_WIDTH, 8, width of one data word and of the serial data field.
REQ-003 Parameter LEN_WIDTH, 4, width of the serial burst-length field; burst = LEN+1 beats (1..2^LEN_WIDTH).
REQ-004 Parameter ACK_TIMEOUT, 64, maximum cycles to wait for target_ack or target_data_out_valid before error.
REQ-005 Clock and reset: clk (input, 1 bit) is the clock; rst_n (input, 1 bit) is the reset, asynchronous, active-low.
REQ-006 bus_data_in  in  1  serial bit, LSB-first, sampled when bus_data_in_valid=1.
REQ-007 bus_data_in_valid  in  1  qualifies bus_data_in; gaps between bits are allowed.
REQ-008 bus_mode  in  1  0 = header bit (address, then length), 1 = write-data bit.
REQ-009 bus_rw  in  1  1 = write burst, 0 = read burst; sampled with the first header bit.
REQ-010 bus_data_out / bus_data_out_valid  out  1/1  serial read data, LSB-first, one bit per valid cycle.
REQ-011 bus_busy  out  1  high from first header bit until burst end.
REQ-012 bus_done / bus_error  out  1/1  single-cycle pulses: burst completed / burst aborted.
REQ-013 target_addr_in / target_addr_in_valid  out  ADDR_WIDTH/1  beat address and one-cycle request strobe.
REQ-014 target_data_in / target_data_in_valid  out  DATA_WIDTH/1  write word and strobe, asserted with the write request.
REQ-015 target_rw  out  1  registered copy of the burst direction, held for the whole burst.
REQ-016 target_ready / target_ack  in  1/1  target may accept a request / beat completed.
REQ-017 target_data_out / target_data_out_valid  in  DATA_WIDTH/1  read word from the target.

Function
REQ-018 States: IDLE, HDR_ADDR, HDR_LEN, WR_COLLECT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_SHIFT, DONE.
REQ-019 IDLE -> HDR_ADDR on the first valid bit with bus_mode=0; the bit counts as address bit 0.
REQ-020 HDR_ADDR collects ADDR_WIDTH valid bits, then HDR_LEN collects LEN_WIDTH valid bits; next state is WR_COLLECT if write, else RD_REQ.
REQ-021 A valid bit whose bus_mode differs from the current field (header vs data), or any valid bit during a read burst after the header: bus_error pulse, no further target requests, return to IDLE.
REQ-022 Write: each DATA_WIDTH valid mode=1 bits form one word moved to a one-entry holding register; the shifter continues collecting the next word while the holding word is in flight.
REQ-023 A new word completing while the holding register is still occupied: overflow, bus_error, IDLE.
REQ-024 Request issue: target_addr_in_valid (plus target_data_in_valid for writes) is a one-cycle pulse, issued only in a cycle with target_ready=1; otherwise held pending.
REQ-025 Write beat completes on target_ack=1; read beat completes on target_data_out_valid=1; target_data_out is captured that cycle.
REQ-026 Read: the captured word is shifted out LSB-first, one bit per cycle, bus_data_out_valid=1 for exactly DATA_WIDTH consecutive cycles; the next read request is issued only after the last bit.
REQ-027 Beat i address = (base + i) mod 2^ADDR_WIDTH; wrap-around is legal.
REQ-028 Timeout counter resets on every request; reaching ACK_TIMEOUT cycles without completion: bus_error, IDLE.
REQ-029 After the final beat completes (final serial bit, for reads): DONE for one cycle, bus_done=1, then IDLE.
REQ-030 target_ack / target_data_out_valid arriving in IDLE or header states is ignored.
REQ-031 bus_done and bus_error are never asserted in the same cycle.

Reset
REQ-032 Asynchronous rst_n=0 forces IDLE; all outputs 0; counters, shifters and the holding register are cleared.
REQ-033 Reset mid-burst discards the burst silently: no done/error pulse; a late target_ack after release is ignored.

Verification (ADDR_WIDTH=16, DATA_WIDTH=8, LEN_WIDTH=4)
REQ-034 Single write: header 0x4A32, LEN=0, data 0x9E -> one request, addr 0x4A32, data 0x9E, target_rw=1; bus_done once after ack.
REQ-035 Burst write 0x11,0x22,0x33,0x44 to 0x4A30, LEN=3, then burst read same -> read requests to 0x4A30..0x4A33; serial output 32 bits decoding to 0x11,0x22,0x33,0x44; one bus_done per burst.
REQ-036 Wrap: write base 0xFFFF, LEN=1, data 0xA5,0x5A -> addresses 0xFFFF then 0x0000.
REQ-037 bus_mode=1 on address bit 5 -> bus_error pulse; no target request; bus_busy=0 next cycle.
REQ-038 Read with target_data_out_valid held 0 -> bus_error exactly ACK_TIMEOUT cycles after the request; the next burst runs normally.
REQ-039 rst_n low during beat 2 of a 4-beat write -> all outputs 0 immediately; no done/error pulse; fresh single write after release succeeds.

Source files
------------

// File: rtl/target_burst_port_if.sv
// target_burst_port_if
//   Bundles the serial host-bus signals and the parallel target-side
//   request/response signals of target_burst_port.
//   modport slave  : view taken by target_burst_port itself.
//   modport master : view taken by the environment (host + target model).
//   Serial side : bus_data_in/_valid, bus_mode, bus_rw (in);
//                 bus_data_out/_valid, bus_busy, bus_done, bus_error (out).
//   Target side : target_addr_in/_valid, target_data_in/_valid, target_rw (out);
//                 target_ready, target_ack, target_data_out/_valid (in).
interface target_burst_port_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  bus_data_in;
  logic                  bus_data_in_valid;
  logic                  bus_mode;
  logic                  bus_rw;
  logic                  bus_data_out;
  logic                  bus_data_out_valid;
  logic                  bus_busy;
  logic                  bus_done;
  logic                  bus_error;
  logic [ADDR_WIDTH-1:0] target_addr_in;
  logic                  target_addr_in_valid;
  logic [DATA_WIDTH-1:0] target_data_in;
  logic                  target_data_in_valid;
  logic                  target_rw;
  logic                  target_ready;
  logic                  target_ack;
  logic [DATA_WIDTH-1:0] target_data_out;
  logic                  target_data_out_valid;

  modport slave (
    input  bus_data_in, bus_data_in_valid, bus_mode, bus_rw,
    output bus_data_out, bus_data_out_valid, bus_busy, bus_done, bus_error,
    output target_addr_in, target_addr_in_valid, target_data_in,
    output target_data_in_valid, target_rw,
    input  target_ready, target_ack, target_data_out, target_data_out_valid
  );

  modport master (
    output bus_data_in, bus_data_in_valid, bus_mode, bus_rw,
    input  bus_data_out, bus_data_out_valid, bus_busy, bus_done, bus_error,
    input  target_addr_in, target_addr_in_valid, target_data_in,
    input  target_data_in_valid, target_rw,
    output target_ready, target_ack, target_data_out, target_data_out_valid
  );
endinterface

// File: rtl/target_burst_port.sv
// target_burst_port
//   Converts a serial, LSB-first host bus into burst transactions on a
//   parallel target port. A header (ADDR_WIDTH address bits then LEN_WIDTH
//   length bits) starts a burst of LEN+1 beats at consecutive addresses.
//   Writes: serial data bits are packed into words and handed to the target
//   through a one-entry holding register. Reads: each returned word is
//   shifted back out on the serial bus before the next beat is requested.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : target_burst_port_if.slave (serial bus + target port)
module target_burst_port #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  target_burst_port_if.slave  bus
);

  localparam int HDR_MAX = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
  localparam int HCW     = $clog2(HDR_MAX + 1);
  localparam int DCW     = $clog2(DATA_WIDTH + 1);
  localparam int TCW     = $clog2(ACK_TIMEOUT + 1);
  localparam int WCW     = LEN_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, HDR_ADDR, HDR_LEN, WR_COLLECT, WR_REQ, WR_WAIT,
    RD_REQ, RD_WAIT, RD_SHIFT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // header shifter, then burst base
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [HCW-1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;         // write collector / read serializer
  logic [DCW-1:0]        bit_q, bit_d;
  logic [WCW-1:0]        words_q, words_d;   // write words packed so far
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [TCW-1:0]        timer_q, timer_d;

  logic req;
  logic err;
  logic shifting;
  logic hold_free;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    len_d      = len_q;
    hdr_cnt_d  = hdr_cnt_q;
    beat_d     = beat_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    words_d    = words_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    timer_d    = timer_q;
    req        = 1'b0;
    err        = 1'b0;
    shifting   = 1'b0;
    hold_free  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Completions arriving here belong to no burst and are ignored.
        if (bus.bus_data_in_valid && !bus.bus_mode) begin
          state_d    = HDR_ADDR;
          rw_d       = bus.bus_rw;
          addr_d     = {bus.bus_data_in, addr_q[ADDR_WIDTH-1:1]};
          hdr_cnt_d  = HCW'(1);
          beat_d     = '0;
          bit_d      = '0;
          words_d    = '0;
          hold_vld_d = 1'b0;
        end
      end

      HDR_ADDR: begin
        if (bus.bus_data_in_valid) begin
          if (bus.bus_mode) begin
            err = 1'b1;
          end else begin
            addr_d = {bus.bus_data_in, addr_q[ADDR_WIDTH-1:1]};
            if (hdr_cnt_q == HCW'(ADDR_WIDTH - 1)) begin
              state_d   = HDR_LEN;
              hdr_cnt_d = '0;
            end else begin
              hdr_cnt_d = hdr_cnt_q + 1'b1;
            end
          end
        end
      end

      HDR_LEN: begin
        if (bus.bus_data_in_valid) begin
          if (bus.bus_mode) begin
            err = 1'b1;
          end else begin
            len_d = {bus.bus_data_in, len_q[LEN_WIDTH-1:1]};
            if (hdr_cnt_q == HCW'(LEN_WIDTH - 1)) begin
              state_d = rw_q ? WR_COLLECT : RD_REQ;
            end else begin
              hdr_cnt_d = hdr_cnt_q + 1'b1;
            end
          end
        end
      end

      WR_COLLECT, WR_REQ, WR_WAIT: begin
        if (state_q == WR_COLLECT && hold_vld_q) begin
          state_d = WR_REQ;
        end
        if (state_q == WR_REQ && bus.target_ready) begin
          req     = 1'b1;
          timer_d = TCW'(1);
          state_d = WR_WAIT;
        end
        if (state_q == WR_WAIT) begin
          if (bus.target_ack) begin
            hold_free  = 1'b1;
            hold_vld_d = 1'b0;
            if (beat_q == len_q) begin
              state_d = DONE;
            end else begin
              beat_d  = beat_q + 1'b1;
              state_d = WR_COLLECT;
            end
          end else if (timer_q == TCW'(ACK_TIMEOUT)) begin
            err = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        // Serial collection runs underneath the beat handshake so the next
        // word can be assembled while the held word is still in flight.
        if (bus.bus_data_in_valid) begin
          if (!bus.bus_mode) begin
            err = 1'b1;
          end else begin
            sh_d = {bus.bus_data_in, sh_q[DATA_WIDTH-1:1]};
            if (bit_q == DCW'(DATA_WIDTH - 1)) begin
              bit_d = '0;
              // A word that would overwrite the held one, or one beyond the
              // burst length, aborts the burst. An ack in this same cycle
              // frees the holding register in time.
              if ((hold_vld_q && !hold_free) ||
                  (words_q == ({1'b0, len_q} + WCW'(1)))) begin
                err = 1'b1;
              end else begin
                hold_d     = sh_d;
                hold_vld_d = 1'b1;
                words_d    = words_q + 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      RD_REQ: begin
        if (bus.bus_data_in_valid) begin
          err = 1'b1;
        end else if (bus.target_ready) begin
          req     = 1'b1;
          timer_d = TCW'(1);
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.bus_data_in_valid) begin
          err = 1'b1;
        end else if (bus.target_data_out_valid) begin
          sh_d    = bus.target_data_out;
          bit_d   = '0;
          state_d = RD_SHIFT;
        end else if (timer_q == TCW'(ACK_TIMEOUT)) begin
          err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RD_SHIFT: begin
        shifting = 1'b1;
        sh_d     = {1'b0, sh_q[DATA_WIDTH-1:1]};
        if (bus.bus_data_in_valid) begin
          err = 1'b1;
        end else if (bit_q == DCW'(DATA_WIDTH - 1)) begin
          bit_d = '0;
          if (beat_q == len_q) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = RD_REQ;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (err) begin
      state_d = IDLE;
      req     = 1'b0;
    end
    if (state_d == IDLE) begin
      rw_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      beat_q     <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      words_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      beat_q     <= beat_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      timer_q    <= timer_d;
    end
  end

  // Address and data are zeroed outside the request strobe.
  assign bus.target_addr_in       = req ? (addr_q + ADDR_WIDTH'(beat_q)) : '0;
  assign bus.target_addr_in_valid = req;
  assign bus.target_data_in       = (req && rw_q) ? hold_q : '0;
  assign bus.target_data_in_valid = req && rw_q;
  assign bus.target_rw            = rw_q;
  assign bus.bus_data_out         = shifting ? sh_q[0] : 1'b0;
  assign bus.bus_data_out_valid   = shifting;
  assign bus.bus_busy             = (state_q != IDLE);
  assign bus.bus_done             = (state_q == DONE);
  assign bus.bus_error            = err;

endmodule

// File: tb/tb_target_burst_port.sv
module tb_target_burst_port;

  logic clk;
  logic rst_n;

  target_burst_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) ifc ();

  target_burst_port #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(4), .ACK_TIMEOUT(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Event log filled on the falling edge.
  int          cyc      = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          both_cnt = 0;
  int          err_cyc  = 0;
  logic [15:0] req_addr [$];
  logic [7:0]  req_data [$];
  logic        req_rw   [$];
  logic        req_dv   [$];
  int          req_cyc  [$];
  logic        out_bits [$];
  int          out_cyc  [$];

  // Target model knobs and state.
  logic        resp_en    = 1'b1;
  int          resp_delay = 0;
  logic        pend       = 1'b0;
  logic        pend_wr    = 1'b0;
  logic [15:0] pend_addr  = '0;
  int          pend_cnt   = 0;
  logic [7:0]  mem [0:65535];

  always @(negedge clk) begin
    cyc++;
    if (ifc.bus_done) done_cnt++;
    if (ifc.bus_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ifc.bus_done && ifc.bus_error) both_cnt++;
    if (ifc.bus_data_out_valid) begin
      out_bits.push_back(ifc.bus_data_out);
      out_cyc.push_back(cyc);
    end
    ifc.target_ack            = 1'b0;
    ifc.target_data_out_valid = 1'b0;
    ifc.target_data_out       = 8'h00;
    if (pend) begin
      if (pend_cnt == 0) begin
        pend = 1'b0;
        if (pend_wr) begin
          ifc.target_ack = 1'b1;
        end else begin
          ifc.target_data_out_valid = 1'b1;
          ifc.target_data_out       = mem[pend_addr];
        end
      end else begin
        pend_cnt--;
      end
    end
    if (ifc.target_addr_in_valid) begin
      req_addr.push_back(ifc.target_addr_in);
      req_data.push_back(ifc.target_data_in);
      req_rw.push_back(ifc.target_rw);
      req_dv.push_back(ifc.target_data_in_valid);
      req_cyc.push_back(cyc);
      if (ifc.target_data_in_valid) mem[ifc.target_addr_in] = ifc.target_data_in;
      pend      = resp_en;
      pend_wr   = ifc.target_rw;
      pend_addr = ifc.target_addr_in;
      pend_cnt  = resp_delay;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic mode, input logic rw);
    ifc.bus_data_in       = b;
    ifc.bus_mode          = mode;
    ifc.bus_rw            = rw;
    ifc.bus_data_in_valid = 1'b1;
    tick();
    ifc.bus_data_in_valid = 1'b0;
    ifc.bus_data_in       = 1'b0;
    ifc.bus_mode          = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] addr, input logic [3:0] len, input logic rw);
    for (int i = 0; i < 16; i++) send_bit(addr[i], 1'b0, rw);
    for (int i = 0; i < 4; i++) send_bit(len[i], 1'b0, rw);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b1, 1'b0);
  endtask

  // Waits for the next done or error pulse, bounded by budget cycles.
  task automatic wait_end(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt + err_cnt;
    n = 0;
    while ((done_cnt + err_cnt) == base && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_bound"}, 32'(n < budget), 32'd1);
    repeat (2) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(ifc.bus_busy), 32'd0);
    check({tag, "_done"}, 32'(ifc.bus_done), 32'd0);
    check({tag, "_err"},  32'(ifc.bus_error), 32'd0);
    check({tag, "_av"},   32'(ifc.target_addr_in_valid), 32'd0);
    check({tag, "_dv"},   32'(ifc.target_data_in_valid), 32'd0);
    check({tag, "_rw"},   32'(ifc.target_rw), 32'd0);
    check({tag, "_ov"},   32'(ifc.bus_data_out_valid), 32'd0);
    check({tag, "_addr"}, 32'(ifc.target_addr_in), 32'd0);
  endtask

  initial begin
    int d0, e0, r0, b0, n;
    logic [7:0] w;
    logic [7:0] exp_w [4];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n                 = 1'b0;
    ifc.bus_data_in       = 1'b0;
    ifc.bus_data_in_valid = 1'b0;
    ifc.bus_mode          = 1'b0;
    ifc.bus_rw            = 1'b0;
    ifc.target_ready      = 1'b1;
    repeat (3) tick();
    check_idle_outputs("rst_active");
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rst_release");

    // Single write, target not ready for a while.
    d0 = done_cnt; e0 = err_cnt; r0 = req_addr.size();
    ifc.target_ready = 1'b0;
    send_header(16'h4A32, 4'h0, 1'b1);
    send_word(8'h9E);
    repeat (5) tick();
    check("t1_no_req_while_not_ready", 32'(req_addr.size()), 32'(r0));
    check("t1_rw_held", 32'(ifc.target_rw), 32'd1);
    check("t1_busy", 32'(ifc.bus_busy), 32'd1);
    ifc.target_ready = 1'b1;
    wait_end("t1", 100);
    check("t1_req_count", 32'(req_addr.size()), 32'(r0 + 1));
    check("t1_addr", 32'(req_addr[r0]), 32'h4A32);
    check("t1_data", 32'(req_data[r0]), 32'h9E);
    check("t1_rw", 32'(req_rw[r0]), 32'd1);
    check("t1_dv", 32'(req_dv[r0]), 32'd1);
    check("t1_done", 32'(done_cnt), 32'(d0 + 1));
    check("t1_err", 32'(err_cnt), 32'(e0));

    // Four-beat write.
    d0 = done_cnt; r0 = req_addr.size();
    send_header(16'h4A30, 4'h3, 1'b1);
    for (int k = 0; k < 4; k++) send_word(exp_w[k]);
    wait_end("t2w", 100);
    check("t2w_req_count", 32'(req_addr.size()), 32'(r0 + 4));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2w_addr%0d", k), 32'(req_addr[r0 + k]), 32'(16'h4A30 + k));
      check($sformatf("t2w_data%0d", k), 32'(req_data[r0 + k]), 32'(exp_w[k]));
    end
    check("t2w_done", 32'(done_cnt), 32'(d0 + 1));

    // Four-beat read of the same words.
    d0 = done_cnt; e0 = err_cnt; r0 = req_addr.size(); b0 = out_bits.size();
    send_header(16'h4A30, 4'h3, 1'b0);
    wait_end("t2r", 300);
    check("t2r_req_count", 32'(req_addr.size()), 32'(r0 + 4));
    check("t2r_bits", 32'(out_bits.size()), 32'(b0 + 32));
    check("t2r_done", 32'(done_cnt), 32'(d0 + 1));
    check("t2r_err", 32'(err_cnt), 32'(e0));
    if (out_bits.size() >= b0 + 32 && req_addr.size() >= r0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t2r_addr%0d", k), 32'(req_addr[r0 + k]), 32'(16'h4A30 + k));
        check($sformatf("t2r_rw%0d", k), 32'(req_rw[r0 + k]), 32'd0);
        for (int j = 0; j < 8; j++) w[j] = out_bits[b0 + 8 * k + j];
        check($sformatf("t2r_word%0d", k), 32'(w), 32'(exp_w[k]));
        check($sformatf("t2r_contig%0d", k),
              32'(out_cyc[b0 + 8 * k + 7] - out_cyc[b0 + 8 * k]), 32'd7);
        if (k < 3)
          check($sformatf("t2r_req_after_bits%0d", k),
                32'(req_cyc[r0 + k + 1] > out_cyc[b0 + 8 * k + 7]), 32'd1);
      end
    end

    // Address wrap-around.
    d0 = done_cnt; r0 = req_addr.size();
    send_header(16'hFFFF, 4'h1, 1'b1);
    send_word(8'hA5);
    send_word(8'h5A);
    wait_end("t3", 100);
    check("t3_req_count", 32'(req_addr.size()), 32'(r0 + 2));
    if (req_addr.size() >= r0 + 2) begin
      check("t3_addr0", 32'(req_addr[r0]), 32'hFFFF);
      check("t3_addr1", 32'(req_addr[r0 + 1]), 32'h0000);
      check("t3_data1", 32'(req_data[r0 + 1]), 32'h5A);
    end
    check("t3_done", 32'(done_cnt), 32'(d0 + 1));

    // Data-mode bit in the middle of the address field.
    d0 = done_cnt; e0 = err_cnt; r0 = req_addr.size();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1, 1'b1);
    check("t4_busy_after", 32'(ifc.bus_busy), 32'd0);
    check("t4_err", 32'(err_cnt), 32'(e0 + 1));
    repeat (3) tick();
    check("t4_err_single", 32'(err_cnt), 32'(e0 + 1));
    check("t4_no_req", 32'(req_addr.size()), 32'(r0));
    check("t4_no_done", 32'(done_cnt), 32'(d0));

    // Read whose data never returns.
    d0 = done_cnt; e0 = err_cnt; r0 = req_addr.size();
    resp_en = 1'b0;
    send_header(16'h1234, 4'h0, 1'b0);
    wait_end("t5", 200);
    resp_en = 1'b1;
    check("t5_err", 32'(err_cnt), 32'(e0 + 1));
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    check("t5_req_count", 32'(req_addr.size()), 32'(r0 + 1));
    if (req_cyc.size() > r0)
      check("t5_timeout_latency", 32'(err_cyc - req_cyc[r0]), 32'd64);
    // The following burst runs normally.
    d0 = done_cnt; b0 = out_bits.size();
    send_header(16'h4A31, 4'h0, 1'b0);
    wait_end("t5n", 100);
    check("t5n_done", 32'(done_cnt), 32'(d0 + 1));
    check("t5n_bits", 32'(out_bits.size()), 32'(b0 + 8));
    if (out_bits.size() >= b0 + 8) begin
      for (int j = 0; j < 8; j++) w[j] = out_bits[b0 + j];
      check("t5n_word", 32'(w), 32'h22);
    end

    // Reset during the second beat of a four-beat write.
    d0 = done_cnt; e0 = err_cnt; r0 = req_addr.size();
    resp_delay = 0;
    send_header(16'h2000, 4'h3, 1'b1);
    send_word(8'h01);
    repeat (6) tick();
    resp_delay = 8;
    send_word(8'h02);
    n = 0;
    while (req_addr.size() < r0 + 2 && n < 20) begin
      tick();
      n++;
    end
    check("t6_beat2_req_bound", 32'(n < 20), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_in_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("t6_no_done", 32'(done_cnt), 32'(d0));
    check("t6_no_err", 32'(err_cnt), 32'(e0));
    check("t6_no_extra_req", 32'(req_addr.size()), 32'(r0 + 2));
    check("t6_idle_busy", 32'(ifc.bus_busy), 32'd0);
    resp_delay = 0;
    d0 = done_cnt; r0 = req_addr.size();
    send_header(16'h0BEE, 4'h0, 1'b1);
    send_word(8'hC3);
    wait_end("t6f", 100);
    check("t6f_req_count", 32'(req_addr.size()), 32'(r0 + 1));
    if (req_addr.size() > r0) begin
      check("t6f_addr", 32'(req_addr[r0]), 32'h0BEE);
      check("t6f_data", 32'(req_data[r0]), 32'hC3);
    end
    check("t6f_done", 32'(done_cnt), 32'(d0 + 1));
    check("t6f_err", 32'(err_cnt), 32'(e0));

    check("done_error_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
